// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite 1:N demultiplexer.
//   RESP_*     : AXI response encodings
//   w_state_e  : write channel FSM states
//   r_state_e  : read channel FSM states
//   idx_w()    : width of a port index for a given port count (minimum 1)
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_DATA
  } r_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4lite_addr_dec.sv
// Combinational address decoder.
//   addr : address to decode
//   idx  : index of the lowest-numbered port whose (addr & MASK[i]) == BASE[i]
//   hit  : 1 when any port matched; idx is 0 when nothing matched
module axi4lite_addr_dec
  import axi4lite_pkg::*;
#(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IDX_W    = idx_w(N_SLAVES),
  parameter logic [N_SLAVES*ADDR_W-1:0] BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              hit
);

  always_comb begin
    idx = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!hit && ((addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W])) begin
        idx = IDX_W'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4lite_demux.sv
// AXI4-Lite 1:N_SLAVES demultiplexer with independent read and write FSMs,
// one outstanding transaction per direction, one register stage toward m_*.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*     : upstream write channels
//   s_ar*/s_r*          : upstream read channels
//   m_*                 : downstream channels, port i in slice i
// Optional: define AXI4LITE_DEMUX_DECERR_EN to answer unmapped addresses with
// DECERR internally; otherwise unmapped addresses go to port 0.
module axi4lite_demux
  import axi4lite_pkg::*;
#(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] MASK = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_W-1:0]              s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_W-1:0]              s_wdata,
  input  logic [DATA_W/8-1:0]            s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_W-1:0]              s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_W-1:0]              s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [N_SLAVES*ADDR_W-1:0]     m_awaddr,
  output logic [N_SLAVES-1:0]            m_awvalid,
  input  logic [N_SLAVES-1:0]            m_awready,
  output logic [N_SLAVES*DATA_W-1:0]     m_wdata,
  output logic [N_SLAVES*DATA_W/8-1:0]   m_wstrb,
  output logic [N_SLAVES-1:0]            m_wvalid,
  input  logic [N_SLAVES-1:0]            m_wready,
  input  logic [N_SLAVES*2-1:0]          m_bresp,
  input  logic [N_SLAVES-1:0]            m_bvalid,
  output logic [N_SLAVES-1:0]            m_bready,
  output logic [N_SLAVES*ADDR_W-1:0]     m_araddr,
  output logic [N_SLAVES-1:0]            m_arvalid,
  input  logic [N_SLAVES-1:0]            m_arready,
  input  logic [N_SLAVES*DATA_W-1:0]     m_rdata,
  input  logic [N_SLAVES*2-1:0]          m_rresp,
  input  logic [N_SLAVES-1:0]            m_rvalid,
  output logic [N_SLAVES-1:0]            m_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = idx_w(N_SLAVES);

  logic [IDX_W-1:0]    aw_idx, ar_idx;
  logic                aw_hit, ar_hit;
  logic [N_SLAVES-1:0] aw_sel_d, ar_sel_d;
  logic                aw_err_d, ar_err_d;

  axi4lite_addr_dec #(.N_SLAVES(N_SLAVES), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                      .BASE(BASE), .MASK(MASK))
    u_aw_dec (.addr(s_awaddr), .idx(aw_idx), .hit(aw_hit));

  axi4lite_addr_dec #(.N_SLAVES(N_SLAVES), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                      .BASE(BASE), .MASK(MASK))
    u_ar_dec (.addr(s_araddr), .idx(ar_idx), .hit(ar_hit));

`ifdef AXI4LITE_DEMUX_DECERR_EN
  assign aw_err_d = !aw_hit;
  assign ar_err_d = !ar_hit;
  assign aw_sel_d = aw_hit ? (N_SLAVES'(1) << aw_idx) : '0;
  assign ar_sel_d = ar_hit ? (N_SLAVES'(1) << ar_idx) : '0;
`else
  assign aw_err_d = 1'b0;
  assign ar_err_d = 1'b0;
  assign aw_sel_d = aw_hit ? (N_SLAVES'(1) << aw_idx) : N_SLAVES'(1);
  assign ar_sel_d = ar_hit ? (N_SLAVES'(1) << ar_idx) : N_SLAVES'(1);
`endif

  // ---------------- write path ----------------
  w_state_e            w_state, w_next;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic [N_SLAVES-1:0] w_sel;
  logic                w_err, aw_done, w_done;
  logic                w_accept, aw_fire, w_fire;
  logic [1:0]          b_resp_t;

  assign m_awaddr = {N_SLAVES{w_addr}};
  assign m_wdata  = {N_SLAVES{w_data}};
  assign m_wstrb  = {N_SLAVES{w_strb}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      w_sel   <= '0;
      w_err   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (w_accept) begin
        w_addr  <= s_awaddr;
        w_data  <= s_wdata;
        w_strb  <= s_wstrb;
        w_sel   <= aw_sel_d;
        w_err   <= aw_err_d;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    b_resp_t = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++)
      if (w_sel[i]) b_resp_t = m_bresp[i*2 +: 2];
  end

  // Ready outputs are gated by rst_n so they stay low while reset is held.
  always_comb begin
    w_next    = w_state;
    w_accept  = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    m_awvalid = '0;
    m_wvalid  = '0;
    m_bready  = '0;
    case (w_state)
      W_IDLE: begin
        if (rst_n && s_awvalid && s_wvalid) begin
          w_accept  = 1'b1;
          s_awready = 1'b1;
          s_wready  = 1'b1;
          w_next    = W_REQ;
        end
      end
      W_REQ: begin
        if (w_err) begin
          w_next = W_RESP;
        end else begin
          m_awvalid = aw_done ? '0 : w_sel;
          m_wvalid  = w_done  ? '0 : w_sel;
          aw_fire   = !aw_done && |(m_awready & w_sel);
          w_fire    = !w_done  && |(m_wready & w_sel);
          if ((aw_done || aw_fire) && (w_done || w_fire)) w_next = W_RESP;
        end
      end
      W_RESP: begin
        if (w_err) begin
          s_bvalid = 1'b1;
          s_bresp  = RESP_DECERR;
        end else begin
          s_bvalid = |(m_bvalid & w_sel);
          s_bresp  = b_resp_t;
          m_bready = s_bready ? w_sel : '0;
        end
        if (s_bvalid && s_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // ---------------- read path ----------------
  r_state_e            r_state, r_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [N_SLAVES-1:0] r_sel;
  logic                r_err, r_accept;
  logic [DATA_W-1:0]   r_data_t;
  logic [1:0]          r_resp_t;

  assign m_araddr = {N_SLAVES{r_addr}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_sel   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= r_next;
      if (r_accept) begin
        r_addr <= s_araddr;
        r_sel  <= ar_sel_d;
        r_err  <= ar_err_d;
      end
    end
  end

  always_comb begin
    r_data_t = '0;
    r_resp_t = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (r_sel[i]) begin
        r_data_t = m_rdata[i*DATA_W +: DATA_W];
        r_resp_t = m_rresp[i*2 +: 2];
      end
    end
  end

  always_comb begin
    r_next    = r_state;
    r_accept  = 1'b0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = RESP_OKAY;
    m_arvalid = '0;
    m_rready  = '0;
    case (r_state)
      R_IDLE: begin
        s_arready = rst_n;
        if (rst_n && s_arvalid) begin
          r_accept = 1'b1;
          r_next   = R_REQ;
        end
      end
      R_REQ: begin
        if (r_err) begin
          r_next = R_DATA;
        end else begin
          m_arvalid = r_sel;
          if (|(m_arready & r_sel)) r_next = R_DATA;
        end
      end
      R_DATA: begin
        if (r_err) begin
          s_rvalid = 1'b1;
          s_rresp  = RESP_DECERR;
        end else begin
          s_rvalid = |(m_rvalid & r_sel);
          s_rdata  = r_data_t;
          s_rresp  = r_resp_t;
          m_rready = s_rready ? r_sel : '0;
        end
        if (s_rvalid && s_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4lite_demux.sv
// Directed self-checking bench for axi4lite_demux with 4 ports at
// 0x0000/0x1000/0x2000/0x3000, mask 0xF000. Honors AXI4LITE_DEMUX_DECERR_EN.
module tb_axi4lite_demux;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] s_awaddr;   logic s_awvalid; logic s_awready;
  logic [DW-1:0] s_wdata;    logic [DW/8-1:0] s_wstrb; logic s_wvalid; logic s_wready;
  logic [1:0]    s_bresp;    logic s_bvalid;  logic s_bready;
  logic [AW-1:0] s_araddr;   logic s_arvalid; logic s_arready;
  logic [DW-1:0] s_rdata;    logic [1:0] s_rresp; logic s_rvalid; logic s_rready;
  logic [N*AW-1:0]   m_awaddr;  logic [N-1:0] m_awvalid; logic [N-1:0] m_awready;
  logic [N*DW-1:0]   m_wdata;   logic [N*DW/8-1:0] m_wstrb;
  logic [N-1:0]      m_wvalid;  logic [N-1:0] m_wready;
  logic [N*2-1:0]    m_bresp;   logic [N-1:0] m_bvalid;  logic [N-1:0] m_bready;
  logic [N*AW-1:0]   m_araddr;  logic [N-1:0] m_arvalid; logic [N-1:0] m_arready;
  logic [N*DW-1:0]   m_rdata;   logic [N*2-1:0] m_rresp;
  logic [N-1:0]      m_rvalid;  logic [N-1:0] m_rready;

  int compared = 0;
  int mismatched = 0;

  axi4lite_demux #(
    .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
    .BASE({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .MASK({4{32'h0000_F000}})
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    m_awready = '0; m_wready = '0; m_bresp = '0; m_bvalid = '0;
    m_arready = '0; m_rdata = '0; m_rresp = '0; m_rvalid = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    #1;
    compared++; if (s_awready !== 1'b0) begin mismatched++; $display("FAIL rst_awready: got %b want 0", s_awready); end
    compared++; if (s_arready !== 1'b0) begin mismatched++; $display("FAIL rst_arready: got %b want 0", s_arready); end
    compared++; if (m_awaddr !== '0 || m_wdata !== '0 || m_araddr !== '0) begin mismatched++; $display("FAIL rst_data: awaddr %h wdata %h araddr %h want 0", m_awaddr, m_wdata, m_araddr); end
    compared++; if ({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid} !== '0) begin mismatched++; $display("FAIL rst_valids: got %b want 0", {m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}); end
    clear_inputs();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    compared++; if (s_arready !== 1'b1) begin mismatched++; $display("FAIL post_rst_arready: got %b want 1", s_arready); end
  endtask

  // First acceptance immediately after reset release; zero-wait slave on port 2.
  task automatic test_write_basic();
    s_awaddr = 32'h2004; s_awvalid = 1'b1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1'b1;
    m_awready = 4'b0100; m_wready = 4'b0100; s_bready = 1'b1;
    #1;
    compared++; if ({s_awready, s_wready} !== 2'b11) begin mismatched++; $display("FAIL wr_accept: got %b want 11", {s_awready, s_wready}); end
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    compared++; if (m_awvalid !== 4'b0100 || m_wvalid !== 4'b0100) begin mismatched++; $display("FAIL wr_route: awvalid %b wvalid %b want 0100", m_awvalid, m_wvalid); end
    compared++; if (m_awaddr[2*AW +: AW] !== 32'h2004) begin mismatched++; $display("FAIL wr_awaddr: got %h want 00002004", m_awaddr[2*AW +: AW]); end
    compared++; if (m_wdata[2*DW +: DW] !== 32'hDEADBEEF || m_wstrb[2*4 +: 4] !== 4'hF) begin mismatched++; $display("FAIL wr_wdata: got %h/%h want deadbeef/f", m_wdata[2*DW +: DW], m_wstrb[2*4 +: 4]); end
    compared++; if (s_awready !== 1'b0) begin mismatched++; $display("FAIL wr_awready_busy: got %b want 0", s_awready); end
    tick();
    compared++; if (m_awvalid !== 4'b0000 || m_bready !== 4'b0100 || s_bvalid !== 1'b0) begin mismatched++; $display("FAIL wr_resp_wait: awvalid %b bready %b bvalid %b want 0000 0100 0", m_awvalid, m_bready, s_bvalid); end
    m_bvalid = 4'b0100; m_bresp = 8'b00_00_00_10;
    #1;
    compared++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin mismatched++; $display("FAIL wr_bresp: bvalid %b bresp %b want 1 00", s_bvalid, s_bresp); end
    tick();
    m_bvalid = '0;
    #1;
    compared++; if (s_bvalid !== 1'b0 || m_bready !== 4'b0000) begin mismatched++; $display("FAIL wr_done: bvalid %b bready %b want 0 0000", s_bvalid, m_bready); end
    clear_inputs();
  endtask

  task automatic test_read_wait();
    s_araddr = 32'h1008; s_arvalid = 1'b1;
    #1;
    compared++; if (s_arready !== 1'b1) begin mismatched++; $display("FAIL rd_arready: got %b want 1", s_arready); end
    tick();
    s_arvalid = 1'b0;
    #1;
    compared++; if (m_arvalid !== 4'b0010 || m_araddr[1*AW +: AW] !== 32'h1008) begin mismatched++; $display("FAIL rd_route: arvalid %b araddr %h want 0010 00001008", m_arvalid, m_araddr[1*AW +: AW]); end
    m_arready = 4'b0010;
    tick();
    m_arready = '0; s_rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      compared++; if (s_arready !== 1'b0 || s_rvalid !== 1'b0 || m_arvalid !== 4'b0000) begin mismatched++; $display("FAIL rd_wait%0d: arready %b rvalid %b arvalid %b want 0 0 0000", i, s_arready, s_rvalid, m_arvalid); end
      tick();
    end
    m_rvalid = 4'b0010; m_rdata[1*DW +: DW] = 32'h12345678; m_rdata[0 +: DW] = 32'hFFFFFFFF;
    #1;
    compared++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h12345678 || s_rresp !== 2'b00) begin mismatched++; $display("FAIL rd_data: rvalid %b rdata %h rresp %b want 1 12345678 00", s_rvalid, s_rdata, s_rresp); end
    compared++; if (m_rready !== 4'b0010) begin mismatched++; $display("FAIL rd_rready: got %b want 0010", m_rready); end
    tick();
    m_rvalid = '0;
    #1;
    compared++; if (s_arready !== 1'b1 || s_rvalid !== 1'b0) begin mismatched++; $display("FAIL rd_done: arready %b rvalid %b want 1 0", s_arready, s_rvalid); end
    clear_inputs();
  endtask

  task automatic test_aw_before_w();
    s_awaddr = 32'h3000; s_awvalid = 1'b1; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'h3; s_wvalid = 1'b1;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; m_awready = 4'b1000;
    #1;
    compared++; if (m_awvalid !== 4'b1000 || m_wvalid !== 4'b1000) begin mismatched++; $display("FAIL aww_start: awvalid %b wvalid %b want 1000 1000", m_awvalid, m_wvalid); end
    tick();
    m_awready = '0;
    for (int i = 0; i < 3; i++) begin
      compared++; if (m_awvalid !== 4'b0000 || m_wvalid !== 4'b1000 || s_bvalid !== 1'b0) begin mismatched++; $display("FAIL aww_wait%0d: awvalid %b wvalid %b bvalid %b want 0000 1000 0", i, m_awvalid, m_wvalid, s_bvalid); end
      if (i == 2) m_wready = 4'b1000;
      tick();
    end
    m_wready = '0; m_bvalid = 4'b1000; m_bresp = 8'b10_00_00_00; s_bready = 1'b1;
    #1;
    compared++; if (m_wvalid !== 4'b0000 || s_bvalid !== 1'b1 || s_bresp !== 2'b10) begin mismatched++; $display("FAIL aww_resp: wvalid %b bvalid %b bresp %b want 0000 1 10", m_wvalid, s_bvalid, s_bresp); end
    tick();
    clear_inputs();
  endtask

  task automatic test_unmapped();
    s_araddr = 32'h9000; s_arvalid = 1'b1;
    m_rdata = {4{32'hCAFEF00D}}; m_rvalid = '0;
    tick();
    s_arvalid = 1'b0;
`ifdef AXI4LITE_DEMUX_DECERR_EN
    #1;
    compared++; if (m_arvalid !== 4'b0000) begin mismatched++; $display("FAIL unm_arvalid: got %b want 0000", m_arvalid); end
    tick();
    s_rready = 1'b1;
    #1;
    compared++; if (s_rvalid !== 1'b1 || s_rresp !== 2'b11 || s_rdata !== 32'h0) begin mismatched++; $display("FAIL unm_decerr: rvalid %b rresp %b rdata %h want 1 11 00000000", s_rvalid, s_rresp, s_rdata); end
    compared++; if (m_rready !== 4'b0000) begin mismatched++; $display("FAIL unm_rready: got %b want 0000", m_rready); end
    tick();
`else
    #1;
    compared++; if (m_arvalid !== 4'b0001 || m_araddr[0 +: AW] !== 32'h9000) begin mismatched++; $display("FAIL unm_port0: arvalid %b araddr %h want 0001 00009000", m_arvalid, m_araddr[0 +: AW]); end
    m_arready = 4'b0001;
    tick();
    m_arready = '0; m_rvalid = 4'b0001; m_rresp = 8'b00_00_00_10; s_rready = 1'b1;
    #1;
    compared++; if (s_rvalid !== 1'b1 || s_rdata !== 32'hCAFEF00D || s_rresp !== 2'b10) begin mismatched++; $display("FAIL unm_rdata: rvalid %b rdata %h rresp %b want 1 cafef00d 10", s_rvalid, s_rdata, s_rresp); end
    tick();
`endif
    #1;
    compared++; if (s_arready !== 1'b1) begin mismatched++; $display("FAIL unm_done: arready %b want 1", s_arready); end
    clear_inputs();
  endtask

  task automatic test_reset_in_resp();
    s_awaddr = 32'h2010; s_awvalid = 1'b1; s_wdata = 32'h55AA55AA; s_wstrb = 4'hF; s_wvalid = 1'b1;
    m_awready = 4'b0100; m_wready = 4'b0100;
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    tick();
    rst_n = 1'b0; m_bvalid = 4'b0100; s_bready = 1'b1;
    #1;
    compared++; if (s_bvalid !== 1'b0 || m_bready !== 4'b0000) begin mismatched++; $display("FAIL rr_outputs: bvalid %b bready %b want 0 0000", s_bvalid, m_bready); end
    compared++; if (m_awaddr !== '0 || m_wdata !== '0 || m_wstrb !== '0) begin mismatched++; $display("FAIL rr_data: awaddr %h wdata %h wstrb %h want 0", m_awaddr, m_wdata, m_wstrb); end
    tick();
    rst_n = 1'b1;
    #1;
    compared++; if (s_bvalid !== 1'b0) begin mismatched++; $display("FAIL rr_silent0: bvalid %b want 0", s_bvalid); end
    tick();
    compared++; if (s_bvalid !== 1'b0 || m_bready !== 4'b0000) begin mismatched++; $display("FAIL rr_silent1: bvalid %b bready %b want 0 0000", s_bvalid, m_bready); end
    clear_inputs();
    s_awaddr = 32'h1004; s_awvalid = 1'b1; s_wdata = 32'h11223344; s_wstrb = 4'hC; s_wvalid = 1'b1;
    m_awready = 4'b0010; m_wready = 4'b0010;
    #1;
    compared++; if ({s_awready, s_wready} !== 2'b11) begin mismatched++; $display("FAIL rr_accept: got %b want 11", {s_awready, s_wready}); end
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    compared++; if (m_awvalid !== 4'b0010 || m_wdata[1*DW +: DW] !== 32'h11223344 || m_wstrb[1*4 +: 4] !== 4'hC) begin mismatched++; $display("FAIL rr_route: awvalid %b wdata %h wstrb %h want 0010 11223344 c", m_awvalid, m_wdata[1*DW +: DW], m_wstrb[1*4 +: 4]); end
    tick();
    m_bvalid = 4'b0010; s_bready = 1'b1;
    #1;
    compared++; if (s_bvalid !== 1'b1 || m_bready !== 4'b0010) begin mismatched++; $display("FAIL rr_bresp: bvalid %b bready %b want 1 0010", s_bvalid, m_bready); end
    tick();
    clear_inputs();
  endtask

  task automatic test_concurrent();
    s_araddr = 32'h3008; s_arvalid = 1'b1;
    s_awaddr = 32'h300C; s_awvalid = 1'b1; s_wdata = 32'h0F0F0F0F; s_wstrb = 4'hF; s_wvalid = 1'b1;
    m_arready = 4'b1000; m_awready = 4'b1000; m_wready = 4'b1000;
    #1;
    compared++; if ({s_arready, s_awready, s_wready} !== 3'b111) begin mismatched++; $display("FAIL cc_accept: got %b want 111", {s_arready, s_awready, s_wready}); end
    tick();
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    #1;
    compared++; if (m_arvalid !== 4'b1000 || m_awvalid !== 4'b1000 || m_wvalid !== 4'b1000) begin mismatched++; $display("FAIL cc_route: ar %b aw %b w %b want 1000", m_arvalid, m_awvalid, m_wvalid); end
    tick();
    m_rvalid = 4'b1000; m_rdata[3*DW +: DW] = 32'h0BADF00D; m_bvalid = 4'b1000;
    s_rready = 1'b0; s_bready = 1'b1;
    #1;
    compared++; if (s_rvalid !== 1'b1 || m_rready !== 4'b0000 || s_bvalid !== 1'b1 || m_bready !== 4'b1000) begin mismatched++; $display("FAIL cc_phase1: rvalid %b rready %b bvalid %b bready %b want 1 0000 1 1000", s_rvalid, m_rready, s_bvalid, m_bready); end
    tick();
    m_bvalid = '0; s_rready = 1'b1; s_bready = 1'b0;
    #1;
    compared++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h0BADF00D || m_rready !== 4'b1000 || s_bvalid !== 1'b0) begin mismatched++; $display("FAIL cc_phase2: rvalid %b rdata %h rready %b bvalid %b want 1 0badf00d 1000 0", s_rvalid, s_rdata, m_rready, s_bvalid); end
    tick();
    m_rvalid = '0;
    #1;
    compared++; if (s_rvalid !== 1'b0 || s_arready !== 1'b1) begin mismatched++; $display("FAIL cc_done: rvalid %b arready %b want 0 1", s_rvalid, s_arready); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_aw_before_w();
    test_unmapped();
    test_reset_in_resp();
    test_concurrent();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi4lite_demux.md
AXI4LITE_DEMUX -- requirements
Module: axi4lite_demux

Interface
REQ-001 SHALL have parameter N_SLAVES, default 4: number of downstream slave ports, range 1..16.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width, 32 or 64; strobe width is DATA_W/8.
REQ-004 SHALL have parameter BASE, default 0: N_SLAVES*ADDR_W packed, per-port base address; port i is slice i.
REQ-005 SHALL have parameter MASK, default 0: N_SLAVES*ADDR_W packed, per-port decode mask.
REQ-006 SHALL have one clock and an asynchronous, active-low reset.
REQ-007 SHALL have clk  in  1  clock, all logic on rising edge.
REQ-008 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have s_*  mixed  per-signal AXI4-Lite  slave port (AR/R/AW/W/B), widths ADDR_W/DATA_W/DATA_W/8/2.
REQ-010 SHALL have m_*  mixed  N_SLAVES x per-signal AXI4-Lite  master ports, packed, port i in slice i.

Function
REQ-011 SHALL decode as: port i hits when (addr & MASK[i]) == BASE[i]; lowest hitting index wins; no hit means unmapped.
REQ-012 SHALL run independent read and write FSMs, each with exactly one outstanding transaction.
REQ-013 Write FSM SHALL use states W_IDLE, W_REQ, W_RESP.
REQ-014 In W_IDLE, s_awready and s_wready SHALL both assert in the same cycle, only when s_awvalid && s_wvalid; addr, data, strb and target are registered; next state W_REQ.
REQ-015 In W_REQ, m_awvalid[t] and m_wvalid[t] SHALL assert one cycle after acceptance and drop individually on their own handshake; when both are done, next state W_RESP.
REQ-016 In W_RESP, s_bvalid/s_bresp SHALL mirror m_bvalid[t]/m_bresp[t] and m_bready[t] SHALL equal s_bready; on the B handshake, next state W_IDLE.
REQ-017 Read FSM SHALL use states R_IDLE (s_arready=1, register addr and target), R_REQ (m_arvalid[t] until m_arready[t]) and R_DATA (m_r* passed through to s_r*, m_rready[t]=s_rready; handshake goes to R_IDLE).
REQ-018 Non-target ports SHALL see every valid and ready low; s_* valid and ready SHALL be low outside the states named above.
REQ-019 Upstream s_* valid/data SHALL NOT be combinationally routed to m_*: one register stage.
REQ-020 Simultaneous read and write to the same port SHALL proceed independently; ordering between them is not guaranteed.
REQ-021 Minimum cost SHALL be: write 3 cycles accept-to-bvalid with zero-wait slave; read 3 cycles accept-to-rvalid.

Reset
REQ-022 On rst_n low, both FSMs SHALL enter IDLE, all valid/ready outputs SHALL be 0, and data outputs SHALL be 0.
REQ-023 Reset mid-transaction SHALL abandon the transaction silently; no response is generated after release.
REQ-024 First acceptance SHALL be possible in the first rising edge after rst_n deasserts.

Configuration
REQ-025 With AXI4LITE_DEMUX_DECERR_EN defined, unmapped accesses SHALL go to an internal responder: no m_* activity; W_REQ lasts 1 cycle, then bresp=2'b11; read returns rresp=2'b11, rdata=0.
REQ-026 Without AXI4LITE_DEMUX_DECERR_EN, unmapped accesses SHALL route to port 0.

Structure
REQ-027 Package axi4lite_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, and the write/read state enums.
REQ-028 Combinational sub-module axi4lite_addr_dec (addr -> index, hit) SHALL be instanced twice, once for AR and once for AW.

Verification
REQ-029 N=4, BASE={0x0000,0x1000,0x2000,0x3000}, MASK=0xF000: write 0x2004 data 0xDEADBEEF strb 0xF -> only port 2 sees AW/W; bresp OKAY relayed.
REQ-030 Read 0x1008 with slave rvalid delayed 5 cycles, rdata 0x12345678 -> s_rdata 0x12345678, s_arready low until R_IDLE.
REQ-031 Slave asserts awready 3 cycles before wready -> m_awvalid drops first, s_bvalid follows W completion only.
REQ-032 Read 0x9000 unmapped -> DECERR_EN: rresp 2'b11, rdata 0, no m_arvalid; else port 0 receives AR.
REQ-033 rst_n pulsed while in W_RESP -> all outputs 0, later write to port 1 completes normally.
REQ-034 Concurrent read of port 3 and write of port 3 with s_bready/s_rready toggling -> both complete, no lost beat.
